// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter: shares one four-lane AES S-box word unit between the
// key-schedule SubWord requester and the four-word SubBytes pass on the
// 128-bit round state.
//
// Handshakes:
//   ks_req is a level request; ks_word is held stable until the one-cycle
//   ks_ack pulse, and ks_result is valid in that same cycle.
//   sb_start is a one-cycle request accepted only while sb_busy is low.
//   sb_state is sampled in the accept cycle only. sb_done pulses for one
//   cycle with sb_out complete.
//
// Optional build macro: SBOX_PIPE_EN adds a register stage on the S-box
// output. The stage is tagged with valid, source and word index.
// All result latencies then grow by one cycle.
module sbox_share_arbiter #(
  parameter bit KS_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ks_req,
  input  logic [31:0]  ks_word,
  output logic         ks_ack,
  output logic [31:0]  ks_result,
  input  logic         sb_start,
  input  logic [127:0] sb_state,
  output logic         sb_busy,
  output logic         sb_done,
  output logic [127:0] sb_out
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (a^254, so 0 maps to 0) followed by
  // the affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
            sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
  endfunction

  logic [127:0] state_q;     // latched SubBytes input
  logic [95:0]  acc_q;       // finished words 0..2 until the last word lands
  logic [1:0]   issue_idx;   // next SubBytes word to send through the S-box
  logic         issue_left;  // SubBytes words still waiting to be issued
  logic         sb_pending;
  logic         ks_blocked;
  logic         ks_cand;
  logic         grant_ks;
  logic         grant_sb;
  logic [31:0]  word_sel;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  // Result seen by the capture logic: the S-box output directly, or the
  // pipeline stage when it is present.
  logic         res_valid;
  logic         res_ks;
  logic [1:0]   res_idx;
  logic [31:0]  res_data;

  assign sb_pending = sb_busy & issue_left;

`ifdef SBOX_PIPE_EN
  logic        stage_valid;
  logic        stage_ks;
  logic [1:0]  stage_idx;
  logic [31:0] stage_data;

  // The ks request stays blocked while its word sits in the stage and in
  // its ack cycle, so at most one ks operation is in flight.
  assign ks_blocked = ks_ack | (stage_valid & stage_ks);

  // Output stage register, tagged with source and word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_ks    <= 1'b0;
      stage_idx   <= 2'd0;
      stage_data  <= 32'h0;
    end else begin
      stage_valid <= grant_ks | grant_sb;
      stage_ks    <= grant_ks;
      stage_idx   <= issue_idx;
      stage_data  <= sbox_out;
    end
  end

  assign res_valid = stage_valid;
  assign res_ks    = stage_ks;
  assign res_idx   = stage_idx;
  assign res_data  = stage_data;
`else
  // A request that is being acked this cycle must not be granted again,
  // because the requester drops it on the ack.
  assign ks_blocked = ks_ack;

  assign res_valid = grant_ks | grant_sb;
  assign res_ks    = grant_ks;
  assign res_idx   = issue_idx;
  assign res_data  = sbox_out;
`endif

  assign ks_cand = ks_req & ~ks_blocked;

  // Arbitration and the S-box input mux: at most one source per cycle.
  always_comb begin
    grant_ks = 1'b0;
    grant_sb = 1'b0;
    word_sel = 32'h0;
    if (KS_PRIORITY) begin
      grant_ks = ks_cand;
      grant_sb = sb_pending & ~ks_cand;
    end else begin
      grant_sb = sb_pending;
      grant_ks = ks_cand & ~sb_pending;
    end
    case (issue_idx)
      2'd0:    word_sel = state_q[127:96];
      2'd1:    word_sel = state_q[95:64];
      2'd2:    word_sel = state_q[63:32];
      default: word_sel = state_q[31:0];
    endcase
    sbox_in = grant_ks ? ks_word : word_sel;
  end

  assign sbox_out = sub_word(sbox_in);

  // Request tracking and result capture for both requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_ack     <= 1'b0;
      ks_result  <= 32'h0;
      sb_busy    <= 1'b0;
      sb_done    <= 1'b0;
      sb_out     <= 128'h0;
      state_q    <= 128'h0;
      acc_q      <= 96'h0;
      issue_idx  <= 2'd0;
      issue_left <= 1'b0;
    end else begin
      ks_ack  <= res_valid & res_ks;
      sb_done <= 1'b0;
      if (res_valid && res_ks) ks_result <= res_data;

      if (sb_start && !sb_busy) begin
        state_q    <= sb_state;
        issue_idx  <= 2'd0;
        issue_left <= 1'b1;
        sb_busy    <= 1'b1;
      end else begin
        if (grant_sb) begin
          issue_idx <= issue_idx + 2'd1;
          if (issue_idx == 2'd3) issue_left <= 1'b0;
        end
        if (res_valid && !res_ks) begin
          case (res_idx)
            2'd0: acc_q[95:64] <= res_data;
            2'd1: acc_q[63:32] <= res_data;
            2'd2: acc_q[31:0]  <= res_data;
            default: begin
              sb_out  <= {acc_q, res_data};
              sb_done <= 1'b1;
              sb_busy <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter. Two instances run side by side:
// u1 with KS_PRIORITY=1 and u0 with KS_PRIORITY=0. They share clock,
// reset and SubBytes inputs, and each has its own ks_req line.
// SBOX_PIPE_EN shifts every expected latency by one cycle.
module tb_sbox_share_arbiter;

`ifdef SBOX_PIPE_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  localparam logic [127:0] VEC_X = 128'h00000000_01010101_53535353_ffffffff;
  localparam logic [127:0] EXP_X = 128'h63636363_7c7c7c7c_edededed_16161616;
  localparam logic [127:0] VEC_Y = 128'hcf4f3c09_00000000_53535353_01010101;
  localparam logic [127:0] EXP_Y = 128'h8a84eb01_63636363_edededed_7c7c7c7c;

  logic         clk = 1'b0;
  logic         rst;
  logic         ks_req1, ks_req0;
  logic [31:0]  ks_word;
  logic         sb_start;
  logic [127:0] sb_state;

  logic         ks_ack1, ks_ack0;
  logic [31:0]  ks_result1, ks_result0;
  logic         sb_busy1, sb_busy0;
  logic         sb_done1, sb_done0;
  logic [127:0] sb_out1, sb_out0;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  sbox_share_arbiter #(.KS_PRIORITY(1'b1)) u1 (
    .clk(clk), .rst(rst), .ks_req(ks_req1), .ks_word(ks_word),
    .ks_ack(ks_ack1), .ks_result(ks_result1), .sb_start(sb_start),
    .sb_state(sb_state), .sb_busy(sb_busy1), .sb_done(sb_done1), .sb_out(sb_out1)
  );

  sbox_share_arbiter #(.KS_PRIORITY(1'b0)) u0 (
    .clk(clk), .rst(rst), .ks_req(ks_req0), .ks_word(ks_word),
    .ks_ack(ks_ack0), .ks_result(ks_result0), .sb_start(sb_start),
    .sb_state(sb_state), .sb_busy(sb_busy0), .sb_done(sb_done0), .sb_out(sb_out0)
  );

  // driver: advance one cycle; inputs set after this take effect at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " u1 busy"}, {127'h0, sb_busy1}, 128'h0);
    chk({tag, " u0 busy"}, {127'h0, sb_busy0}, 128'h0);
    chk({tag, " u1 done"}, {127'h0, sb_done1}, 128'h0);
    chk({tag, " u0 done"}, {127'h0, sb_done0}, 128'h0);
    chk({tag, " u1 ack"},  {127'h0, ks_ack1},  128'h0);
    chk({tag, " u0 ack"},  {127'h0, ks_ack0},  128'h0);
  endtask

  initial begin
    rst      = 1'b1;
    ks_req1  = 1'b0;
    ks_req0  = 1'b0;
    ks_word  = 32'h0;
    sb_start = 1'b0;
    sb_state = 128'h0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk_idle("reset");
    chk("reset u1 ks_result", {96'h0, ks_result1}, 128'h0);
    chk("reset u0 sb_out", sb_out0, 128'h0);

    // key-schedule request alone; dropped on ack, so only one ack
    ks_req1 = 1'b1;
    ks_req0 = 1'b1;
    ks_word = 32'hcf4f3c09;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("ks alone u1 ack k=%0d", k), {127'h0, ks_ack1}, {127'h0, k == 1 + L});
      chk($sformatf("ks alone u0 ack k=%0d", k), {127'h0, ks_ack0}, {127'h0, k == 1 + L});
      if (k == 1 + L) begin
        chk("ks alone u1 result", {96'h0, ks_result1}, {96'h0, 32'h8a84eb01});
        chk("ks alone u0 result", {96'h0, ks_result0}, {96'h0, 32'h8a84eb01});
        ks_req1 = 1'b0;
        ks_req0 = 1'b0;
      end
    end

    // SubBytes alone
    sb_start = 1'b1;
    sb_state = VEC_X;
    for (int k = 1; k <= 7; k++) begin
      tick();
      sb_start = 1'b0;
      chk($sformatf("sb alone u1 busy k=%0d", k), {127'h0, sb_busy1}, {127'h0, k <= 4 + L});
      chk($sformatf("sb alone u0 busy k=%0d", k), {127'h0, sb_busy0}, {127'h0, k <= 4 + L});
      chk($sformatf("sb alone u1 done k=%0d", k), {127'h0, sb_done1}, {127'h0, k == 5 + L});
      chk($sformatf("sb alone u0 done k=%0d", k), {127'h0, sb_done0}, {127'h0, k == 5 + L});
      if (k == 5 + L) begin
        chk("sb alone u1 out", sb_out1, EXP_X);
        chk("sb alone u0 out", sb_out0, EXP_X);
      end
    end

    // contention: ks request arrives two cycles after sb_start
    sb_start = 1'b1;
    sb_state = VEC_Y;
    ks_word  = 32'h00000000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      sb_start = 1'b0;
      chk($sformatf("cont u1 ack k=%0d", k),  {127'h0, ks_ack1},  {127'h0, k == 3 + L});
      chk($sformatf("cont u1 done k=%0d", k), {127'h0, sb_done1}, {127'h0, k == 6 + L});
      chk($sformatf("cont u0 ack k=%0d", k),  {127'h0, ks_ack0},  {127'h0, k == 6 + L});
      chk($sformatf("cont u0 done k=%0d", k), {127'h0, sb_done0}, {127'h0, k == 5 + L});
      if (k == 3 + L) begin
        chk("cont u1 result", {96'h0, ks_result1}, {96'h0, 32'h63636363});
        ks_req1 = 1'b0;
      end
      if (k == 6 + L) begin
        chk("cont u0 result", {96'h0, ks_result0}, {96'h0, 32'h63636363});
        chk("cont u1 out", sb_out1, EXP_Y);
        ks_req0 = 1'b0;
      end
      if (k == 5 + L) chk("cont u0 out", sb_out0, EXP_Y);
      if (k == 2) begin
        ks_req1 = 1'b1;
        ks_req0 = 1'b1;
      end
    end

    // sb_start while busy is ignored
    sb_start = 1'b1;
    sb_state = VEC_X;
    for (int k = 1; k <= 8; k++) begin
      tick();
      sb_start = 1'b0;
      if (k == 2) begin
        sb_start = 1'b1;
        sb_state = VEC_Y;
      end
      chk($sformatf("ignore u1 busy k=%0d", k), {127'h0, sb_busy1}, {127'h0, k <= 4 + L});
      chk($sformatf("ignore u0 done k=%0d", k), {127'h0, sb_done0}, {127'h0, k == 5 + L});
      if (k == 5 + L) begin
        chk("ignore u1 out", sb_out1, EXP_X);
        chk("ignore u0 out", sb_out0, EXP_X);
      end
    end

    // reset during word 2 aborts silently; inputs ignored while rst=1
    sb_start = 1'b1;
    sb_state = VEC_Y;
    for (int k = 1; k <= 8; k++) begin
      tick();
      sb_start = 1'b0;
      rst      = 1'b0;
      ks_req1  = 1'b0;
      ks_req0  = 1'b0;
      if (k <= 3) begin
        chk($sformatf("abort u1 busy k=%0d", k), {127'h0, sb_busy1}, 128'h1);
      end else begin
        chk_idle($sformatf("abort k=%0d", k));
        chk($sformatf("abort u1 out k=%0d", k), sb_out1, 128'h0);
        chk($sformatf("abort u0 out k=%0d", k), sb_out0, 128'h0);
        chk($sformatf("abort u1 ks_result k=%0d", k), {96'h0, ks_result1}, 128'h0);
      end
      if (k == 3) begin
        rst      = 1'b1;
        sb_start = 1'b1;
        ks_req1  = 1'b1;
        ks_req0  = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
- Time-multiplexes one 32-bit four-lane S-box word substitution unit (the team's SBox4: four S-boxes, one per byte, combinational) between two requesters.
- Requester 1 is the key-schedule SubWord request; requester 2 is the round SubBytes operation on the 128-bit state.
- SubBytes runs as four word passes through the shared unit. Key-schedule requests are interleaved according to a fixed priority.
- Sits between the round controller, the key-expansion unit and the shared S-box instance.

Parameters:
- KS_PRIORITY, 1: 1 = key-schedule request wins contention; 0 = SubBytes words win, and a key-schedule request waits until no SubBytes word is pending.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ks_req  in  1  key-schedule request, level; held high with ks_word stable until ks_ack.
- ks_word  in  32  word to substitute.
- ks_ack  out  1  one-cycle pulse; ks_result valid in the same cycle.
- ks_result  out  32  registered SubWord(ks_word); holds its value until the next ks completion.
- sb_start  in  1  start SubBytes on sb_state; accepted only when sb_busy=0.
- sb_state  in  128  state input; sampled only in the accept cycle.
- sb_busy  out  1  high while any word of the state is pending.
- sb_done  out  1  one-cycle pulse; sb_out complete in the same cycle.
- sb_out  out  128  registered SubBytes result; holds its value until the next completion.

Behaviour:
- Reset: all outputs 0, state register 0, word index 0, every in-flight operation discarded, no ack/done generated. Reset mid-operation aborts silently. sb_start and ks_req are ignored while rst=1.
- Word order: index 0 = bits [127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0]. The result for index i is written to the same slice of sb_out.
- SubBytes accept: sb_start=1 and sb_busy=0 in cycle T latches sb_state and sets index=0; sb_busy=1 from T+1.
- sb_start while sb_busy=1: ignored; latched state unchanged.
- Grant: each cycle the S-box input mux selects at most one source.
  - Candidates: ks (ks_req=1 and ks not blocked), or the pending SubBytes word at the current index.
  - The selected result is captured into its register at the clock edge ending that cycle.
- ks blocking: ks is not eligible in a cycle where ks_ack=1. This prevents double service of a request being dropped. Maximum key-schedule rate is one per 2 cycles.
- ks latency: granted in cycle t, then ks_ack=1 and ks_result valid in t+1.
- SubBytes latency without contention:
  - Words 0..3 are processed in T+1..T+4.
  - sb_done=1 and sb_busy=0 in T+5.
  - A new sb_start is accepted in T+5.
- Contention: each cycle lost to a ks grant delays the remaining words and sb_done by exactly one cycle. With KS_PRIORITY=1 and continuous ks traffic, SubBytes still advances at least every other cycle.
- KS_PRIORITY=0: ks is granted only in cycles with no SubBytes word pending, including the sb_done cycle and idle cycles.
- Simultaneous sb_start and ks_req in the same idle cycle: ks is granted in that cycle (no word pending yet); SubBytes proceeds from T+1.
- Outputs come directly from registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SBOX_PIPE_EN.
- Defined:
  - A register stage is inserted on the S-box output, tagged with valid, source (ks/sb) and index.
  - All latencies grow by 1: ks_ack at t+2; sb_done at T+6 without contention.
  - ks remains blocked from its grant until the cycle after ks_ack, so at most one ks is in flight.
  - SubBytes words may be issued back-to-back.
  - sb_busy stays high until the last word leaves the stage.
  - Reset clears the stage's valid bit.
- Undefined: single-stage behaviour exactly as described above.

Test Plan:
- Idle, ks_req=1, ks_word=32'hcf4f3c09 → ks_ack the next cycle, ks_result=32'h8a84eb01; ks_req dropped on ack → no second ack.
- sb_start with sb_state=128'h00000000_01010101_53535353_ffffffff, no ks traffic → sb_done exactly 5 cycles after the start cycle, sb_out=128'h63636363_7c7c7c7c_edededed_16161616, sb_busy high for 4 cycles.
- KS_PRIORITY=1: ks_req asserted 2 cycles after sb_start, ks_word=32'h00000000 → ks_ack with ks_result=32'h63636363; sb_done delayed by exactly 1 cycle; sb_out still correct.
- KS_PRIORITY=0, same stimulus → ks_ack only in the cycle after sb_done; sb_done at start+5.
- sb_start pulsed again while sb_busy=1 with different data → ignored; first result unchanged. rst asserted during word 2 → sb_busy=0, no sb_done, sb_out=0.
- SBOX_PIPE_EN defined: repeat the first two tests → ks_ack at grant+2; sb_done at start+6 with identical values.
